mod_add_sub_seq: RTL and testbench

Limb-serial modular adder/subtractor computing (a + b) mod P or (a − b) mod P for N-bit field operands. It processes one W-bit limb per cycle and sits between the field-arithmetic scheduler and the register file, behind valid/ready handshakes on both sides. It generalises the combinational N-bit add/sub with these additions: modular reduction, a configurable limb width, multi-cycle operation and backpressure.

---
 rtl/mod_arith_pkg.sv | 12 +
 rtl/limb_add_sub.sv | 24 ++
 rtl/mod_add_sub_seq.sv | 127 ++++++++++++
 tb/tb_mod_add_sub_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mod_arith_pkg.sv
// rtl/mod_arith_pkg.sv - shared types and constants for the modular add/sub datapath
package mod_arith_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mas_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // 2^255 - 19
    localparam logic [255:0] P25519 = {4'h7, {61{4'hF}}, 8'hED};

endpackage

// File: rtl/limb_add_sub.sv
// rtl/limb_add_sub.sv - combinational W-bit add/subtract cell with carry/borrow in and out
module limb_add_sub #(
    parameter int W = 64
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    input  logic         sub,
    output logic [W-1:0] z,
    output logic         cout
);

    logic [W:0] acc;

    // In subtract mode the extra top bit of the W+1-bit result is the borrow out
    always_comb begin
        if (sub) acc = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, cin};
        else     acc = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
    end

    assign z    = acc[W-1:0];
    assign cout = acc[W];

endmodule

// File: rtl/mod_add_sub_seq.sv
// rtl/mod_add_sub_seq.sv - limb-serial (a +/- b) mod P with valid/ready handshakes
module mod_add_sub_seq
    import mod_arith_pkg::*;
#(
    parameter int             N = 256,
    parameter int             W = 64,
    parameter logic [N-1:0]   P = P25519[N-1:0]
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         wrap
);

    localparam int L  = N / W;
    localparam int IW = (L > 1) ? $clog2(L) : 1;

    if (N % W != 0) begin : g_bad_limb
        $error("mod_add_sub_seq: N must be a multiple of W");
    end
    if (P == '0) begin : g_bad_mod
        $error("mod_add_sub_seq: P must be non-zero");
    end

    mas_state_t     state, state_n;
    logic [IW-1:0]  idx;
    logic [N-1:0]   a_r, b_r, s_r, t_r;
    logic           op_r, c_s, c_t;

    logic [W-1:0]   s_i, t_i;
    logic           cs_o, ct_o;
    logic [N-1:0]   s_full, t_full;
    logic           wrap_n, last;

    assign last = (idx == IW'(L - 1));

    limb_add_sub #(.W(W)) u_s_cell (
        .x    (a_r[idx*W +: W]),
        .y    (b_r[idx*W +: W]),
        .cin  (c_s),
        .sub  (op_r),
        .z    (s_i),
        .cout (cs_o)
    );

    // T path applies the correction in the opposite direction to the S path
    limb_add_sub #(.W(W)) u_t_cell (
        .x    (s_i),
        .y    (P[idx*W +: W]),
        .cin  (c_t),
        .sub  (~op_r),
        .z    (t_i),
        .cout (ct_o)
    );

    always_comb begin
        s_full = s_r;
        t_full = t_r;
        s_full[idx*W +: W] = s_i;
        t_full[idx*W +: W] = t_i;
        wrap_n = (op_r == OP_ADD) ? (cs_o | ~ct_o) : cs_o;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid)  state_n = RUN;
            RUN:     if (last)      state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default:                state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= OP_ADD;
            c_s    <= 1'b0;
            c_t    <= 1'b0;
            s_r    <= '0;
            t_r    <= '0;
            result <= '0;
            wrap   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r  <= a;
                        b_r  <= b;
                        op_r <= op;
                        idx  <= '0;
                        c_s  <= 1'b0;
                        c_t  <= 1'b0;
                    end
                end
                RUN: begin
                    s_r <= s_full;
                    t_r <= t_full;
                    c_s <= cs_o;
                    c_t <= ct_o;
                    if (last) begin
                        result <= wrap_n ? t_full : s_full;
                        wrap   <= wrap_n;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_mod_add_sub_seq.sv
// tb/tb_mod_add_sub_seq.sv - directed and randomized checks of mod_add_sub_seq against an arithmetic model
module tb_mod_add_sub_seq;

    localparam int N = 256;
    localparam int W = 64;
    localparam int L = N / W;
    localparam logic [N-1:0] PM = {4'h7, {61{4'hF}}, 8'hED};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] result;
    logic         wrap;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mod_add_sub_seq #(.N(N), .W(W), .P(PM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .wrap      (wrap)
    );

    task automatic check(input string tag, input logic [N:0] obs, input logic [N:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N:0] model(input logic o, input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N+1:0] s;
        if (o == 1'b0) begin
            s = {2'b0, x} + {2'b0, y};
            if (s >= {2'b0, PM}) return {1'b1, N'(s - {2'b0, PM})};
            return {1'b0, N'(s)};
        end
        if (x >= y) return {1'b0, x - y};
        s = {2'b0, x} + {2'b0, PM} - {2'b0, y};
        return {1'b1, N'(s)};
    endfunction

    function automatic logic [N-1:0] rand_operand();
        logic [N-1:0] v;
        do begin
            for (int k = 0; k < N / 32; k++) v[k*32 +: 32] = $urandom;
            case ($urandom_range(0, 3))
                0: v = PM - N'($urandom_range(1, 4));
                1: v = N'($urandom_range(0, 4));
                default: v[N-1] = 1'b0;
            endcase
        end while (v >= PM);
        return v;
    endfunction

    // Issues one request at a negedge, returns result/wrap and edges from acceptance to out_valid.
    task automatic do_op(input logic o, input logic [N-1:0] x, input logic [N-1:0] y,
                         input int extra_hold, output logic [N:0] got, output int lat);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        lat = 0;
        while (!in_ready && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
        for (int k = 0; k < extra_hold; k++) begin @(posedge clk); @(negedge clk); end
        got = {wrap, result};
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [N:0]   got, exp;
    logic [N-1:0] hold_res;
    int           lat;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_in_ready", N'(in_ready), 1);
        check("reset_out_valid", N'(out_valid), 0);
        check("reset_result", {wrap, result}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(1'b0, 5, 7, 0, got, lat);
        check("add_5_7", got, {1'b0, N'(12)});
        check("add_5_7_latency", N'(lat), L + 1);
        check("idle_after_handshake", N'({in_ready, out_valid}), 2'b10);

        do_op(1'b0, PM - 1, 2, 0, got, lat);
        check("add_pm1_2", got, {1'b1, N'(1)});

        do_op(1'b0, {192'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 1, 0, got, lat);
        check("add_limb_carry", got, {1'b0, N'(1) << 64});

        do_op(1'b1, 3, 5, 0, got, lat);
        check("sub_3_5", got, {1'b1, (N'(1) << 255) - N'(21)});
        check("sub_3_5_latency", N'(lat), L + 1);

        do_op(1'b1, PM - 1, PM - 1, 0, got, lat);
        check("sub_equal", got, {1'b0, N'(0)});

        // Backpressure in DONE with in_valid pulses that must be ignored
        op = 1'b0; a = 100; b = 23; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
        hold_res = result;
        check("bp_first", {wrap, result}, {1'b0, N'(123)});
        for (int k = 0; k < 3; k++) begin
            in_valid = k[0]; a = 1; b = 1;
            @(posedge clk); @(negedge clk);
            check("bp_out_valid", N'(out_valid), 1);
            check("bp_in_ready", N'(in_ready), 0);
            check("bp_result_stable", N'(result), hold_res);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_in_ready", N'(in_ready), 1);
        check("bp_release_out_valid", N'(out_valid), 0);
        repeat (6) @(negedge clk);
        check("bp_no_phantom_result", N'(out_valid), 0);

        // Reset during RUN while limb 2 is being processed
        op = 1'b0; a = 40; b = 2; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", N'(out_valid), 0);
        check("rst_in_ready", N'(in_ready), 1);
        check("rst_result", {wrap, result}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("rst_no_emission", N'(out_valid), 0);
        do_op(1'b0, 1, 1, 0, got, lat);
        check("after_rst_add", got, {1'b0, N'(2)});

        for (int n = 0; n < 2000; n++) begin
            logic         o;
            logic [N-1:0] x, y;
            o = 1'(($urandom & 1));
            x = rand_operand();
            y = rand_operand();
            if ($urandom_range(0, 7) == 0) y = x;
            exp = model(o, x, y);
            do_op(o, x, y, $urandom_range(0, 2), got, lat);
            check("random_op", got, exp);
            if (lat != L + 1) check("random_latency", N'(lat), L + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
